// File: rtl/frame_pkg.sv
// Shared types and default sizing for the orbit-frame bank sequencer.
package frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWAP,
        S_GUARD,
        S_READ,
        S_DRAIN
    } fbs_state_t;

    localparam int FRAME_LEN_D = 2048;
    localparam int RD_LAT_D    = 2;
    localparam int GUARD_D     = 2;

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth shift register aligning read-side flags with frame-buffer data.
module valid_delay #(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/frame_bank_sched.sv
// Ping-pong bank sequencer: swaps SW at frame boundaries and streams the read
// bank to the serializer under txReady, flagging overrun/underrun.
module frame_bank_sched
    import frame_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_D,
    parameter int ADDR_W    = 11,
    parameter int RD_LAT    = RD_LAT_D,
    parameter int GUARD     = GUARD_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrDone,
    input  logic              anyWE,
    input  logic              txReady,
    output logic              SW,
    output logic              RE,
    output logic [ADDR_W-1:0] rAddr,
    output logic              rdValid,
    output logic              frameEnd,
    output logic              overrun,
    output logic              underrun,
    output logic [15:0]       frameCnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    fbs_state_t        state_q;
    logic              pending_q, sw_q, re_q, ovr_q, und_q;
    logic [ADDR_W-1:0] raddr_q, nxt_q;
    logic [7:0]        cnt_q;
    logic [15:0]       fcnt_q;
    logic              last_rd;
    logic [1:0]        vd_q;

    assign last_rd = re_q && (raddr_q == LAST_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            sw_q      <= 1'b0;
            re_q      <= 1'b0;
            ovr_q     <= 1'b0;
            und_q     <= 1'b0;
            raddr_q   <= '0;
            nxt_q     <= '0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
        end else begin
            ovr_q <= wrDone && pending_q;
            und_q <= 1'b0;
            if (wrDone) pending_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    // A wrDone landing on the swap edge belongs to the next frame
                    if (pending_q && !anyWE) begin
                        state_q <= S_SWAP;
                        if (!wrDone) pending_q <= 1'b0;
                    end
                end
                S_SWAP: begin
                    sw_q    <= ~sw_q;
                    fcnt_q  <= fcnt_q + 16'd1;
                    cnt_q   <= '0;
                    state_q <= S_GUARD;
                end
                S_GUARD: begin
                    if (cnt_q == 8'(GUARD - 1)) begin
                        state_q <= S_READ;
                        re_q    <= txReady;
                        raddr_q <= '0;
                        nxt_q   <= ADDR_W'(txReady);
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_READ: begin
                    // nxt_q tracks the next address so stalls never re-issue a word
                    if (last_rd) begin
                        re_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_DRAIN;
                    end else if (txReady) begin
                        re_q    <= 1'b1;
                        raddr_q <= nxt_q;
                        nxt_q   <= nxt_q + ADDR_W'(1);
                    end else begin
                        re_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == 8'(RD_LAT - 1)) begin
                        state_q <= S_IDLE;
                        und_q   <= !pending_q;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    valid_delay #(.W(2), .DEPTH(RD_LAT)) u_vdly (
        .clk   (clk),
        .rst_n (rst),
        .d_i   ({re_q, last_rd}),
        .q_o   (vd_q)
    );

    assign SW       = sw_q;
    assign RE       = re_q;
    assign rAddr    = raddr_q;
    assign rdValid  = vd_q[1];
    assign frameEnd = vd_q[0];
    assign overrun  = ovr_q;
    assign underrun = und_q;
    assign frameCnt = fcnt_q;

endmodule

// File: tb/tb_frame_bank_sched.sv
// Bench for frame_bank_sched: per-cycle reference model plus scenario table.
module tb_frame_bank_sched;

    localparam int FL = 2048;
    localparam int RL = 2;
    localparam int GD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrDone = 1'b0, anyWE = 1'b0, txReady = 1'b0;
    logic        SW, RE, rdValid, frameEnd, overrun, underrun;
    logic [10:0] rAddr;
    logic [15:0] frameCnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_bank_sched dut (
        .clk(clk), .rst(rst), .wrDone(wrDone), .anyWE(anyWE), .txReady(txReady),
        .SW(SW), .RE(RE), .rAddr(rAddr), .rdValid(rdValid), .frameEnd(frameEnd),
        .overrun(overrun), .underrun(underrun), .frameCnt(frameCnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
            if (errors >= 40) begin
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    endtask

    // Reference model: countdown timers for guard/drain, address = words issued so far.
    bit          m_sw, m_re, m_ovr, m_und, m_pend, m_swap;
    int          m_guard, m_reads, m_drain, m_addr;
    logic [15:0] m_cnt;
    bit [RL-1:0] vp_re, vp_fe;

    task automatic model_reset();
        m_sw = 0; m_re = 0; m_ovr = 0; m_und = 0; m_pend = 0; m_swap = 0;
        m_guard = 0; m_reads = 0; m_drain = 0; m_addr = 0; m_cnt = '0;
        vp_re = '0; vp_fe = '0;
    endtask

    task automatic issue(input bit rdy);
        if (rdy) begin
            m_re = 1;
            m_addr = FL - m_reads;
            m_reads--;
            if (m_reads == 0) m_drain = RL + 1;
        end else begin
            m_re = 0;
        end
    endtask

    task automatic model_step(input bit wr, input bit we, input bit rdy);
        bit new_pend;
        vp_re = (vp_re << 1) | RL'(m_re);
        vp_fe = (vp_fe << 1) | RL'(m_re && m_addr == FL - 1);
        new_pend = m_pend || wr;
        m_ovr = wr && m_pend;
        m_und = 0;
        if (m_swap) begin
            m_sw = !m_sw; m_cnt = m_cnt + 16'd1; m_swap = 0; m_guard = GD; m_re = 0;
        end else if (m_guard > 0) begin
            m_guard--;
            m_re = 0;
            if (m_guard == 0) begin
                m_reads = FL; m_addr = 0;
                issue(rdy);
            end
        end else if (m_reads > 0) begin
            issue(rdy);
        end else if (m_drain > 0) begin
            m_re = 0;
            m_drain--;
            if (m_drain == 0 && !m_pend) m_und = 1;
        end else begin
            m_re = 0;
            if (m_pend && !we) begin
                m_swap = 1;
                new_pend = wr;
            end
        end
        m_pend = new_pend;
    endtask

    always @(negedge rst) model_reset();

    always @(posedge clk) if (rst) model_step(wrDone, anyWE, txReady);

    always @(negedge clk) begin
        logic [32:0] act, exp;
        act = {SW, RE, rAddr, rdValid, frameEnd, overrun, underrun, frameCnt};
        exp = {m_sw, m_re, 11'(m_addr), vp_re[RL-1], vp_fe[RL-1], m_ovr, m_und, m_cnt};
        chk("cycle_outputs", act, exp);
    end

    typedef struct {
        int n_wr;     // wrDone pulses injected during the first readout
        int rmode;    // 0 ready high, 1 toggling, 2 random
        int hold;     // anyWE cycles after the frame ends
        int exp_ovr;
        int exp_und;
        int exp_cnt;
        int exp_sw;
        int exp_dly;  // negedges from frameEnd to SW toggle, -1 = none
    } vec_t;

    vec_t vt[6];

    task automatic do_reset();
        wrDone = 0; anyWE = 0; txReady = 0;
        @(negedge clk); #2 rst = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1;
    endtask

    task automatic pulse_wr();
        @(posedge clk); #1 wrDone = 1;
        @(posedge clk); #1 wrDone = 0;
    endtask

    task automatic sw_delay(input string name);
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            if (SW || c > 20) break;
            c++;
        end
        chk(name, c, 2);
    endtask

    initial begin
        #900000;
        chk("global_timeout", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int  c, nv, u, w, reads, ovr, und, after, dly, H;
        bit  done, fe, inj1, inj2, swfe;

        vt[0] = '{0, 0, 0, 0, 1, 1, 1, -1};
        vt[1] = '{0, 1, 0, 0, 1, 1, 1, -1};
        vt[2] = '{1, 0, 0, 0, 0, 2, 0, 3};
        vt[3] = '{2, 1, 0, 1, 0, 2, 0, 3};
        vt[4] = '{1, 0, 5, 0, 0, 2, 0, 8};
        vt[5] = '{2, 2, 3, 1, 0, 2, 0, 6};

        #1 rst = 0;
        @(negedge clk);
        chk("reset_SW", SW, 0);
        chk("reset_RE", RE, 0);
        chk("reset_rAddr", rAddr, 0);
        chk("reset_rdValid", rdValid, 0);
        chk("reset_frameEnd", frameEnd, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_underrun", underrun, 0);
        chk("reset_frameCnt", frameCnt, 0);
        #2 rst = 1;

        // First frame: swap latency, guard length, full readout, underrun
        txReady = 1;
        pulse_wr();
        c = 0;
        forever begin
            @(negedge clk);
            if (SW || c > 20) break;
            c++;
        end
        chk("sw_toggle_delay", c, 2);
        while (!RE && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("first_re_delay", c, 2 + GD);
        nv = 0; w = 0;
        while (!frameEnd && w < 6000) begin
            @(negedge clk);
            w++;
            if (rdValid) nv++;
        end
        chk("frame_end_seen", frameEnd, 1);
        chk("rdvalid_count", nv, FL);
        chk("frame_cnt_1", frameCnt, 1);
        u = 0;
        repeat (8) begin
            @(negedge clk);
            if (underrun) u++;
        end
        chk("underrun_pulses", u, 1);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            txReady = 1;
            pulse_wr();
            reads = 0; ovr = 0; und = 0; after = 0; dly = -1;
            done = 0; fe = 0; inj1 = 0; inj2 = 0; swfe = 0;
            H = vt[i].hold;
            for (int cyc = 0; cyc < 7000 && !done; cyc++) begin
                case (vt[i].rmode)
                    0: txReady = 1;
                    1: txReady = (cyc % 2 == 0);
                    default: txReady = ($urandom_range(0, 3) != 0);
                endcase
                wrDone = 0;
                if (vt[i].n_wr >= 1 && !inj1 && reads >= 500) begin
                    wrDone = 1; inj1 = 1;
                end else if (vt[i].n_wr >= 2 && !inj2 && reads >= 1000) begin
                    wrDone = 1; inj2 = 1;
                end
                anyWE = fe && (after < H);
                @(negedge clk);
                if (RE && !fe) reads++;
                if (overrun) ovr++;
                if (underrun) und++;
                if (fe) begin
                    after++;
                    if (SW != swfe && dly < 0) dly = after;
                    if (after >= 10 + H) done = 1;
                end else if (frameEnd) begin
                    fe = 1;
                    swfe = SW;
                end
                if (!done) begin
                    @(posedge clk);
                    #1;
                end
            end
            wrDone = 0; anyWE = 0;
            chk($sformatf("vec%0d_done", i), done, 1);
            chk($sformatf("vec%0d_reads", i), reads, FL);
            chk($sformatf("vec%0d_overrun", i), ovr, vt[i].exp_ovr);
            chk($sformatf("vec%0d_underrun", i), und, vt[i].exp_und);
            chk($sformatf("vec%0d_frameCnt", i), frameCnt, vt[i].exp_cnt);
            chk($sformatf("vec%0d_SW", i), SW, vt[i].exp_sw);
            chk($sformatf("vec%0d_swap_delay", i), dly, vt[i].exp_dly);
        end

        // Reset in the middle of a readout
        do_reset();
        txReady = 1;
        pulse_wr();
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(RE && rAddr == 11'd1000) && w < 3000);
        chk("abort_reached_addr", rAddr, 1000);
        #2 rst = 0;
        #1;
        chk("abort_SW", SW, 0);
        chk("abort_RE", RE, 0);
        chk("abort_rAddr", rAddr, 0);
        chk("abort_rdValid", rdValid, 0);
        chk("abort_frameCnt", frameCnt, 0);
        @(negedge clk);
        #2 rst = 1;
        fe = 0;
        repeat (20) begin
            @(negedge clk);
            if (frameEnd) fe = 1;
        end
        chk("abort_no_frameEnd", fe, 0);
        chk("abort_SW_held", SW, 0);
        pulse_wr();
        sw_delay("abort_restart_sw_delay");

        // Randomized traffic, checked cycle by cycle against the model
        do_reset();
        H = 0;
        for (int cyc = 0; cyc < 25000; cyc++) begin
            @(posedge clk);
            #1;
            txReady = ($urandom_range(0, 3) != 0);
            wrDone = ($urandom_range(0, 999) == 0);
            if (H > 0) H--;
            else if ($urandom_range(0, 49) == 0) H = $urandom_range(1, 8);
            anyWE = (H > 0);
        end
        @(negedge clk);
        chk("random_frames_swapped", frameCnt >= 16'd3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
